// File: rtl/shift_serializer.sv
//------------------------------------------------------------------------------
// Module  : shift_serializer
// Brief   : Parallel-to-serial framer with valid/ready input, stall and
//           gapless back-to-back words.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_hold,
  output logic             o_ser_dout,
  output logic             o_ser_valid,
  output logic             o_frame_start,
  output logic             o_frame_done,
  output logic             o_busy
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   ZERO_CNT = '0;
  localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic             w_in_shift;
  logic             w_last;
  logic             w_release;
  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out_bit;

  // Output end of the shift register and its 0-filled advance toward it.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    assign w_out_bit = shreg_q[WIDTH-1];
  end else begin : g_lsb_first
    assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    assign w_out_bit = shreg_q[0];
  end

  assign w_in_shift = (state_q == S_SHIFT);
  assign w_last     = w_in_shift && (bit_cnt_q == LAST_CNT);
  assign w_release  = w_last && !i_hold;
  assign w_ready    = !w_in_shift || w_release;
  assign w_accept   = w_ready && i_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          shreg_d   = i_data;
          bit_cnt_d = ZERO_CNT;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!i_hold) begin
          if (w_last) begin
            // Reload on the last bit so the next word follows with no gap.
            if (w_accept) begin
              shreg_d   = i_data;
              bit_cnt_d = ZERO_CNT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            shreg_d   = w_shifted;
            bit_cnt_d = bit_cnt_q + ONE_CNT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_ready       = w_ready;
    o_busy        = w_in_shift;
    o_ser_valid   = w_in_shift;
    o_ser_dout    = w_in_shift && w_out_bit;
    o_frame_start = w_in_shift && (bit_cnt_q == ZERO_CNT);
    o_frame_done  = w_release;
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_serializer.sv
//------------------------------------------------------------------------------
// Module  : tb_shift_serializer
// Brief   : Directed self-checking bench for shift_serializer (MSB and LSB first).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_serializer;

  logic       clk;
  logic       rst_n;

  logic       m_valid, m_hold;
  logic [7:0] m_data;
  logic       m_ready, m_dout, m_sval, m_start, m_done, m_busy;

  logic       l_valid, l_hold;
  logic [7:0] l_data;
  logic       l_ready, l_dout, l_sval, l_start, l_done, l_busy;

  int n_total;
  int n_bad;

  shift_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_dut_m (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (m_valid),
    .o_ready      (m_ready),
    .i_data       (m_data),
    .i_hold       (m_hold),
    .o_ser_dout   (m_dout),
    .o_ser_valid  (m_sval),
    .o_frame_start(m_start),
    .o_frame_done (m_done),
    .o_busy       (m_busy)
  );

  shift_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_dut_l (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (l_valid),
    .o_ready      (l_ready),
    .i_data       (l_data),
    .i_hold       (l_hold),
    .o_ser_dout   (l_dout),
    .o_ser_valid  (l_sval),
    .o_frame_start(l_start),
    .o_frame_done (l_done),
    .o_busy       (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on the MSB-first instance; expectations are per cycle,
  // leftmost bit of each mask = first cycle after the accepting edge.
  task automatic send_m(input string tag, input logic [7:0] data, input int n,
                        input logic [31:0] hold_m, input logic [31:0] dout_m,
                        input logic [31:0] start_m, input logic [31:0] done_m,
                        input logic [31:0] ready_m);
    m_valid = 1'b1;
    m_data  = data;
    m_hold  = 1'b0;
    @(negedge clk);
    chk({tag, ".acc_ready"}, 32'(m_ready), 32'd1);
    chk({tag, ".acc_sval"},  32'(m_sval),  32'd0);
    next_cycle();
    m_valid = 1'b0;
    m_data  = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      m_hold = hold_m[n-1-i];
      @(negedge clk);
      chk($sformatf("%s.dout%0d", tag, i),  32'(m_dout),  32'(dout_m[n-1-i]));
      chk($sformatf("%s.start%0d", tag, i), 32'(m_start), 32'(start_m[n-1-i]));
      chk($sformatf("%s.done%0d", tag, i),  32'(m_done),  32'(done_m[n-1-i]));
      chk($sformatf("%s.ready%0d", tag, i), 32'(m_ready), 32'(ready_m[n-1-i]));
      chk($sformatf("%s.sval%0d", tag, i),  32'(m_sval),  32'd1);
      chk($sformatf("%s.busy%0d", tag, i),  32'(m_busy),  32'd1);
      next_cycle();
    end
    m_hold = 1'b0;
    @(negedge clk);
    chk({tag, ".end_ready"}, 32'(m_ready), 32'd1);
    chk({tag, ".end_sval"},  32'(m_sval),  32'd0);
    chk({tag, ".end_busy"},  32'(m_busy),  32'd0);
    next_cycle();
  endtask

  initial begin
    int busy_cnt;
    logic [15:0] stream;
    logic [7:0]  lsb_exp;
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    m_valid = 1'b0; m_hold = 1'b0; m_data = 8'h00;
    l_valid = 1'b0; l_hold = 1'b0; l_data = 8'h00;

    // Reset state
    #12;
    chk("rst.m_ready", 32'(m_ready), 32'd1);
    chk("rst.m_sval",  32'(m_sval),  32'd0);
    chk("rst.m_busy",  32'(m_busy),  32'd0);
    chk("rst.m_dout",  32'(m_dout),  32'd0);
    chk("rst.m_start", 32'(m_start), 32'd0);
    chk("rst.m_done",  32'(m_done),  32'd0);
    chk("rst.l_ready", 32'(l_ready), 32'd1);
    chk("rst.l_sval",  32'(l_sval),  32'd0);
    rst_n = 1'b1;
    next_cycle();
    next_cycle();

    // 8'hA5 MSB first
    send_m("a5", 8'hA5, 8, 32'b0, 32'b10100101, 32'b10000000, 32'b00000001, 32'b00000001);

    // 8'h01 LSB first: 1 then seven 0s, busy exactly 8 cycles
    lsb_exp  = 8'b10000000;
    busy_cnt = 0;
    l_valid  = 1'b1;
    l_data   = 8'h01;
    @(negedge clk);
    chk("lsb.acc_ready", 32'(l_ready), 32'd1);
    next_cycle();
    l_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (l_busy) busy_cnt++;
      if (i < 8) begin
        chk($sformatf("lsb.dout%0d", i), 32'(l_dout), 32'(lsb_exp[7-i]));
      end
      next_cycle();
    end
    chk("lsb.busy_cycles", 32'(busy_cnt), 32'd8);

    // Back-to-back 8'hF0 then 8'h0F with i_valid held
    stream  = 16'b1111000000001111;
    m_valid = 1'b1;
    m_data  = 8'hF0;
    @(negedge clk);
    chk("b2b.acc_ready", 32'(m_ready), 32'd1);
    next_cycle();
    m_data = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) m_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b.dout%0d", i),  32'(m_dout),  32'(stream[15-i]));
      chk($sformatf("b2b.sval%0d", i),  32'(m_sval),  32'd1);
      chk($sformatf("b2b.ready%0d", i), 32'(m_ready), (i == 7 || i == 15) ? 32'd1 : 32'd0);
      chk($sformatf("b2b.start%0d", i), 32'(m_start), (i == 0 || i == 8) ? 32'd1 : 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("b2b.end_sval", 32'(m_sval), 32'd0);
    next_cycle();

    // Hold on bit 3 for 3 cycles, then hold on the last bit for 2 cycles
    send_m("hold3", 8'hA5, 11, 32'b00011100000, 32'b10100000101,
           32'b10000000000, 32'b00000000001, 32'b00000000001);
    send_m("holdl", 8'hA5, 10, 32'b0000000110, 32'b1010010111,
           32'b1000000000, 32'b0000000001, 32'b0000000001);

    // Asynchronous reset after bit 4, then a clean word
    m_valid = 1'b1;
    m_data  = 8'hA5;
    next_cycle();
    m_valid = 1'b0;
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    chk("mid.busy_before", 32'(m_busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.sval", 32'(m_sval),  32'd0);
    chk("mid.ready", 32'(m_ready), 32'd1);
    chk("mid.busy", 32'(m_busy),  32'd0);
    next_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    send_m("3c", 8'h3C, 8, 32'b0, 32'b00111100, 32'b10000000, 32'b00000001, 32'b00000001);

    // Idle with random data/hold and no valid
    for (int i = 0; i < 10; i++) begin
      m_valid = 1'b0;
      m_data  = 8'($urandom);
      m_hold  = 1'($urandom);
      @(negedge clk);
      chk($sformatf("idle.sval%0d", i),  32'(m_sval),  32'd0);
      chk($sformatf("idle.ready%0d", i), 32'(m_ready), 32'd1);
      chk($sformatf("idle.busy%0d", i),  32'(m_busy),  32'd0);
      chk($sformatf("idle.dout%0d", i),  32'(m_dout),  32'd0);
      next_cycle();
    end
    m_hold = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
